// File: rtl/dcache_pkg.sv
// Shared types and helpers for the direct-mapped write-through data cache.
// Holds the controller FSM encoding, array geometry and byte-lane helpers.
// No logic of its own; imported by the controller.
package dcache_pkg;

    localparam int TAG_WIDTH = 27;
    localparam int SET_WIDTH = 3;

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_REFILL = 2'd1,
        ST_WRITE  = 2'd2
    } state_t;

    // One-hot byte-lane strobe for a byte offset within a word.
    function automatic logic [3:0] byte_strobe(input logic [1:0] off);
        byte_strobe = 4'b0001 << off;
    endfunction

    // Load result: whole word for LW, zero-extended little-endian byte for LBU.
    function automatic logic [31:0] load_extract(input logic [31:0] word,
                                                 input logic        is_byte,
                                                 input logic [1:0]  off);
        logic [31:0] sh;
        sh = word >> {off, 3'b000};
        load_extract = is_byte ? {24'h0, sh[7:0]} : word;
    endfunction

endpackage

// File: rtl/dcache_array.sv
// Valid/tag/data storage: one combinational read port, one byte-enabled write port.
// Latency: read same cycle, write visible after the next clk edge.
// Backpressure: none; the controller guarantees at most one write per cycle.
module dcache_array #(
    parameter int DATA_WIDTH = 32,
    parameter int TAG_WIDTH  = dcache_pkg::TAG_WIDTH,
    parameter int SET_WIDTH  = dcache_pkg::SET_WIDTH
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic                    i_clr,
    input  logic [SET_WIDTH-1:0]    i_rd_set,
    output logic                    o_rd_vld,
    output logic [TAG_WIDTH-1:0]    o_rd_tag,
    output logic [DATA_WIDTH-1:0]   o_rd_dat,
    input  logic                    i_wr_en,
    input  logic [SET_WIDTH-1:0]    i_wr_set,
    input  logic [TAG_WIDTH-1:0]    i_wr_tag,
    input  logic [DATA_WIDTH-1:0]   i_wr_dat,
    input  logic [DATA_WIDTH/8-1:0] i_wr_be
);
    localparam int NSETS = 1 << SET_WIDTH;
    localparam int NB    = DATA_WIDTH / 8;

    logic [NSETS-1:0]      r_valid;
    logic [TAG_WIDTH-1:0]  r_tag  [NSETS];
    logic [DATA_WIDTH-1:0] r_data [NSETS];

    assign o_rd_vld = r_valid[i_rd_set];
    assign o_rd_tag = r_tag[i_rd_set];
    assign o_rd_dat = r_data[i_rd_set];

    // Valid bits: cleared by reset or bulk flush, set by any line write.
    always_ff @(posedge clk) begin
        if (rst || i_clr) begin
            r_valid <= '0;
        end else if (i_wr_en) begin
            r_valid[i_wr_set] <= 1'b1;
        end
    end

    // Tag and data: only the enabled byte lanes of the word are overwritten.
    always_ff @(posedge clk) begin
        if (i_wr_en) begin
            r_tag[i_wr_set] <= i_wr_tag;
            for (int b = 0; b < NB; b++) begin
                if (i_wr_be[b]) begin
                    r_data[i_wr_set][b*8 +: 8] <= i_wr_dat[b*8 +: 8];
                end
            end
        end
    end

endmodule

// File: rtl/dcache_ctrl.sv
// Direct-mapped, one-word-line, write-through data cache controller (optional stats: DCACHE_STATS_EN).
// Latency: load hit same cycle; load miss / any store completes on the mem_ack cycle.
// Backpressure: cpu_stall holds the pipeline; single outstanding mem transaction, held until mem_ack.
module dcache_ctrl #(
    parameter int DATA_WIDTH = 32,
    parameter int TAG_WIDTH  = dcache_pkg::TAG_WIDTH,
    parameter int SET_WIDTH  = dcache_pkg::SET_WIDTH
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  cpu_req,
    input  logic                  cpu_we,
    input  logic                  cpu_byte,
    input  logic [31:0]           cpu_addr,
    input  logic [DATA_WIDTH-1:0] cpu_wdata,
    output logic [DATA_WIDTH-1:0] cpu_rdata,
    output logic                  cpu_stall,
    input  logic                  flush,
    output logic                  mem_req,
    output logic                  mem_we,
    output logic [31:0]           mem_addr,
    output logic [DATA_WIDTH-1:0] mem_wdata,
    output logic [3:0]            mem_wstrb,
    input  logic [DATA_WIDTH-1:0] mem_rdata,
    input  logic                  mem_ack
`ifdef DCACHE_STATS_EN
    ,
    output logic [31:0]           hit_count,
    output logic [31:0]           miss_count
`endif
);
    import dcache_pkg::*;

    state_t r_state, w_next;

    logic                  r_mem_req, r_mem_we;
    logic [31:0]           r_mem_addr;
    logic [DATA_WIDTH-1:0] r_mem_wdata;
    logic [3:0]            r_mem_wstrb;
    logic                  r_byte;
    logic [1:0]            r_off;
    logic                  r_st_hit;

    logic [SET_WIDTH-1:0]  w_set;
    logic [TAG_WIDTH-1:0]  w_tag;
    logic                  w_rd_vld;
    logic [TAG_WIDTH-1:0]  w_rd_tag;
    logic [DATA_WIDTH-1:0] w_rd_dat;
    logic                  w_hit;

    logic                  w_stall, w_issue, w_done, w_clr, w_wr_en;
    logic [DATA_WIDTH-1:0] w_rdata, w_wr_dat;
    logic [3:0]            w_wr_be;

    assign w_set = cpu_addr[2 +: SET_WIDTH];
    assign w_tag = cpu_addr[31 -: TAG_WIDTH];
    assign w_hit = w_rd_vld && (w_rd_tag == w_tag);

    dcache_array #(
        .DATA_WIDTH (DATA_WIDTH),
        .TAG_WIDTH  (TAG_WIDTH),
        .SET_WIDTH  (SET_WIDTH)
    ) u_array (
        .clk      (clk),
        .rst      (rst),
        .i_clr    (w_clr),
        .i_rd_set (w_set),
        .o_rd_vld (w_rd_vld),
        .o_rd_tag (w_rd_tag),
        .o_rd_dat (w_rd_dat),
        .i_wr_en  (w_wr_en),
        .i_wr_set (r_mem_addr[2 +: SET_WIDTH]),
        .i_wr_tag (r_mem_addr[31 -: TAG_WIDTH]),
        .i_wr_dat (w_wr_dat),
        .i_wr_be  (w_wr_be)
    );

    // FSM state register.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_state <= ST_IDLE;
        end else begin
            r_state <= w_next;
        end
    end

    // Next state, CPU-side outputs and array write control.
    always_comb begin
        w_next   = r_state;
        w_stall  = 1'b0;
        w_rdata  = '0;
        w_issue  = 1'b0;
        w_done   = 1'b0;
        w_clr    = 1'b0;
        w_wr_en  = 1'b0;
        w_wr_dat = r_mem_wdata;
        w_wr_be  = r_mem_wstrb;
        case (r_state)
            ST_IDLE: begin
                // Flush wins over a simultaneous request; the request is retried later.
                if (flush) begin
                    w_stall = 1'b1;
                    w_clr   = 1'b1;
                end else if (cpu_req) begin
                    if (cpu_we) begin
                        w_stall = 1'b1;
                        w_issue = 1'b1;
                        w_next  = ST_WRITE;
                    end else if (w_hit) begin
                        w_rdata = load_extract(w_rd_dat, cpu_byte, cpu_addr[1:0]);
                    end else begin
                        w_stall = 1'b1;
                        w_issue = 1'b1;
                        w_next  = ST_REFILL;
                    end
                end
            end
            ST_REFILL: begin
                w_stall = 1'b1;
                if (mem_ack) begin
                    w_stall  = 1'b0;
                    w_done   = 1'b1;
                    w_wr_en  = 1'b1;
                    w_wr_dat = mem_rdata;
                    w_wr_be  = 4'hF;
                    w_rdata  = load_extract(mem_rdata, r_byte, r_off);
                    w_next   = ST_IDLE;
                end
            end
            ST_WRITE: begin
                w_stall = 1'b1;
                if (mem_ack) begin
                    w_stall = 1'b0;
                    w_done  = 1'b1;
                    // Byte stores never allocate; they only patch a line already present.
                    w_wr_en = r_st_hit || !r_byte;
                    w_next  = ST_IDLE;
                end
            end
            default: begin
                w_next = ST_IDLE;
            end
        endcase
        // Reset abandons any transaction and quiets the CPU side immediately.
        if (rst) begin
            w_stall = 1'b0;
            w_rdata = '0;
            w_issue = 1'b0;
            w_done  = 1'b0;
            w_clr   = 1'b0;
            w_wr_en = 1'b0;
        end
    end

    // Memory-side request registers, captured on issue and held until mem_ack.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_mem_req   <= 1'b0;
            r_mem_we    <= 1'b0;
            r_mem_addr  <= '0;
            r_mem_wdata <= '0;
            r_mem_wstrb <= '0;
            r_byte      <= 1'b0;
            r_off       <= '0;
            r_st_hit    <= 1'b0;
        end else if (w_issue) begin
            r_mem_req   <= 1'b1;
            r_mem_we    <= cpu_we;
            r_mem_addr  <= {cpu_addr[31:2], 2'b00};
            r_mem_wdata <= !cpu_we ? '0 :
                           cpu_byte ? {(DATA_WIDTH/8){cpu_wdata[7:0]}} : cpu_wdata;
            r_mem_wstrb <= !cpu_we ? 4'h0 :
                           cpu_byte ? byte_strobe(cpu_addr[1:0]) : 4'hF;
            r_byte      <= cpu_byte;
            r_off       <= cpu_addr[1:0];
            r_st_hit    <= w_hit;
        end else if (w_done) begin
            r_mem_req   <= 1'b0;
            r_mem_we    <= 1'b0;
            r_mem_wstrb <= 4'h0;
        end
    end

    assign mem_req   = r_mem_req;
    assign mem_we    = r_mem_we;
    assign mem_addr  = r_mem_addr;
    assign mem_wdata = r_mem_wdata;
    assign mem_wstrb = r_mem_wstrb;
    assign cpu_stall = w_stall;
    assign cpu_rdata = w_rdata;

`ifdef DCACHE_STATS_EN
    logic [31:0] r_hit_cnt, r_miss_cnt;
    logic        w_ev_hit, w_ev_miss;

    // A completed access is a load hit in IDLE or any mem_ack-terminated access.
    always_comb begin
        w_ev_hit  = 1'b0;
        w_ev_miss = 1'b0;
        if (!rst) begin
            if (r_state == ST_IDLE && !flush && cpu_req && !cpu_we && w_hit) begin
                w_ev_hit = 1'b1;
            end
            if (r_state == ST_REFILL && mem_ack) begin
                w_ev_miss = 1'b1;
            end
            if (r_state == ST_WRITE && mem_ack) begin
                w_ev_hit  = r_st_hit;
                w_ev_miss = !r_st_hit;
            end
        end
    end

    // Saturating hit/miss counters.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_hit_cnt  <= '0;
            r_miss_cnt <= '0;
        end else begin
            if (w_ev_hit && r_hit_cnt != 32'hFFFF_FFFF) begin
                r_hit_cnt <= r_hit_cnt + 32'd1;
            end
            if (w_ev_miss && r_miss_cnt != 32'hFFFF_FFFF) begin
                r_miss_cnt <= r_miss_cnt + 32'd1;
            end
        end
    end

    assign hit_count  = r_hit_cnt;
    assign miss_count = r_miss_cnt;
`endif

endmodule

// File: tb/tb_dcache_ctrl.sv
// Self-checking bench for dcache_ctrl: table of CPU accesses plus hand sequences
// for flush and mid-refill reset. Memory responds with mem_ack on the third
// cycle of mem_req. Inputs change at posedge+1, outputs sampled at negedge.
module tb_dcache_ctrl;

    logic        clk = 1'b0;
    logic        rst;
    logic        cpu_req, cpu_we, cpu_byte, flush;
    logic [31:0] cpu_addr, cpu_wdata, cpu_rdata;
    logic        cpu_stall;
    logic        mem_req, mem_we, mem_ack;
    logic [31:0] mem_addr, mem_wdata, mem_rdata;
    logic [3:0]  mem_wstrb;
`ifdef DCACHE_STATS_EN
    logic [31:0] hit_count, miss_count;
`endif

    int total = 0;
    int bad   = 0;

    typedef struct {
        logic        we;
        logic        bt;
        logic [31:0] addr;
        logic [31:0] wdata;
        logic [31:0] mrdata;
        logic [31:0] exp_rdata;
        int          exp_stalls;
        logic        exp_mem;
        logic [3:0]  exp_wstrb;
        logic [31:0] exp_mwdata;
    } vec_t;

    vec_t exp_q[$];
    vec_t vecs[15];

    always #5 clk = ~clk;

    dcache_ctrl dut (
        .clk       (clk),
        .rst       (rst),
        .cpu_req   (cpu_req),
        .cpu_we    (cpu_we),
        .cpu_byte  (cpu_byte),
        .cpu_addr  (cpu_addr),
        .cpu_wdata (cpu_wdata),
        .cpu_rdata (cpu_rdata),
        .cpu_stall (cpu_stall),
        .flush     (flush),
        .mem_req   (mem_req),
        .mem_we    (mem_we),
        .mem_addr  (mem_addr),
        .mem_wdata (mem_wdata),
        .mem_wstrb (mem_wstrb),
        .mem_rdata (mem_rdata),
        .mem_ack   (mem_ack)
`ifdef DCACHE_STATS_EN
        ,
        .hit_count (hit_count),
        .miss_count(miss_count)
`endif
    );

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %h want %h", name, act, exp);
        end
    endtask

    function automatic vec_t mk(input logic we, input logic bt, input logic [31:0] addr,
                                input logic [31:0] wdata, input logic [31:0] mrdata,
                                input logic [31:0] exp_rdata, input int exp_stalls,
                                input logic exp_mem, input logic [3:0] exp_wstrb,
                                input logic [31:0] exp_mwdata);
        vec_t v;
        v.we = we; v.bt = bt; v.addr = addr; v.wdata = wdata; v.mrdata = mrdata;
        v.exp_rdata = exp_rdata; v.exp_stalls = exp_stalls; v.exp_mem = exp_mem;
        v.exp_wstrb = exp_wstrb; v.exp_mwdata = exp_mwdata;
        return v;
    endfunction

    // Called at posedge+1; returns at posedge+1 with the request dropped.
    task automatic run_access(input string lbl, input vec_t v);
        int          stalls = 0;
        int          mcyc   = 0;
        logic        done   = 1'b0;
        logic        ack_next = 1'b0;
        logic        saw_mem = 1'b0;
        logic        rdz_ok = 1'b1;
        logic [31:0] cap_addr = '0;
        logic [31:0] cap_wdata = '0;
        logic [3:0]  cap_wstrb = '0;
        logic        cap_we = 1'b0;
        vec_t        e;
        cpu_req = 1'b1; cpu_we = v.we; cpu_byte = v.bt;
        cpu_addr = v.addr; cpu_wdata = v.wdata; mem_rdata = v.mrdata; mem_ack = 1'b0;
        exp_q.push_back(v);
        for (int cyc = 0; cyc < 40 && !done; cyc++) begin
            if (cyc > 0) begin
                @(posedge clk); #1;
                mem_ack = ack_next;
            end
            @(negedge clk);
            if (mem_req) begin
                mcyc++;
                if (!saw_mem) begin
                    cap_addr = mem_addr; cap_wdata = mem_wdata;
                    cap_wstrb = mem_wstrb; cap_we = mem_we;
                end
                saw_mem = 1'b1;
            end
            if (cpu_stall) begin
                stalls++;
                if (cpu_rdata !== 32'h0) rdz_ok = 1'b0;
                ack_next = (mcyc >= 2);
            end else begin
                done = 1'b1;
                e = exp_q.pop_front();
                check({lbl, ".rdata"}, cpu_rdata, e.exp_rdata);
            end
        end
        @(posedge clk); #1;
        cpu_req = 1'b0; mem_ack = 1'b0;
        if (!done) begin
            total++; bad++;
            $display("FAIL %s.timeout: no completion within 40 cycles", lbl);
            void'(exp_q.pop_front());
        end else begin
            check({lbl, ".stalls"}, stalls, v.exp_stalls);
            check({lbl, ".memreq"}, {31'h0, saw_mem}, {31'h0, v.exp_mem});
            check({lbl, ".rdata_zero_while_stalled"}, {31'h0, rdz_ok}, 32'h1);
            if (saw_mem && v.exp_mem) begin
                check({lbl, ".mem_addr"}, cap_addr, {v.addr[31:2], 2'b00});
                check({lbl, ".mem_we"}, {31'h0, cap_we}, {31'h0, v.we});
                if (v.we) begin
                    check({lbl, ".mem_wstrb"}, {28'h0, cap_wstrb}, {28'h0, v.exp_wstrb});
                    check({lbl, ".mem_wdata"}, cap_wdata, v.exp_mwdata);
                end
            end
        end
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        //            we  bt   addr          wdata         mrdata        exp_rdata    st mem strb   mwdata
        vecs[0]  = mk(0, 0, 32'h0001_0000, 32'h0,        32'hDEADBEEF, 32'hDEADBEEF, 3, 1, 4'h0, 32'h0);
        vecs[1]  = mk(0, 0, 32'h0001_0000, 32'h0,        32'h0,        32'hDEADBEEF, 0, 0, 4'h0, 32'h0);
        vecs[2]  = mk(0, 1, 32'h0001_0002, 32'h0,        32'h0,        32'h0000_00AD, 0, 0, 4'h0, 32'h0);
        vecs[3]  = mk(1, 1, 32'h0001_0001, 32'h5A,       32'h0,        32'h0,        3, 1, 4'b0010, 32'h5A5A5A5A);
        vecs[4]  = mk(0, 0, 32'h0001_0000, 32'h0,        32'h0,        32'hDEAD5AEF, 0, 0, 4'h0, 32'h0);
        vecs[5]  = mk(1, 1, 32'h0002_0003, 32'h77,       32'h0,        32'h0,        3, 1, 4'b1000, 32'h77777777);
        vecs[6]  = mk(0, 1, 32'h0002_0003, 32'h0,        32'h11223344, 32'h0000_0011, 3, 1, 4'h0, 32'h0);
        vecs[7]  = mk(0, 0, 32'h0001_0020, 32'h0,        32'hCAFEF00D, 32'hCAFEF00D, 3, 1, 4'h0, 32'h0);
        vecs[8]  = mk(0, 0, 32'h0001_0000, 32'h0,        32'hDEAD5AEF, 32'hDEAD5AEF, 3, 1, 4'h0, 32'h0);
        vecs[9]  = mk(0, 0, 32'h0001_0020, 32'h0,        32'hCAFEF00D, 32'hCAFEF00D, 3, 1, 4'h0, 32'h0);
        vecs[10] = mk(1, 0, 32'h0003_0004, 32'h01020304, 32'h0,        32'h0,        3, 1, 4'hF, 32'h01020304);
        vecs[11] = mk(0, 0, 32'h0003_0004, 32'h0,        32'h0,        32'h01020304, 0, 0, 4'h0, 32'h0);
        vecs[12] = mk(0, 1, 32'h0003_0007, 32'h0,        32'h0,        32'h0000_0001, 0, 0, 4'h0, 32'h0);
        vecs[13] = mk(1, 0, 32'h0003_0004, 32'hA5A5A5A5, 32'h0,        32'h0,        3, 1, 4'hF, 32'hA5A5A5A5);
        vecs[14] = mk(0, 1, 32'h0003_0004, 32'h0,        32'h0,        32'h0000_00A5, 0, 0, 4'h0, 32'h0);

        rst = 1'b1; cpu_req = 1'b0; cpu_we = 1'b0; cpu_byte = 1'b0; flush = 1'b0;
        cpu_addr = '0; cpu_wdata = '0; mem_rdata = '0; mem_ack = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        @(negedge clk);
        check("rst.mem_req", {31'h0, mem_req}, 32'h0);
        check("rst.cpu_stall", {31'h0, cpu_stall}, 32'h0);
        check("rst.cpu_rdata", cpu_rdata, 32'h0);
        check("rst.mem_addr", mem_addr, 32'h0);
        check("rst.mem_wstrb", {28'h0, mem_wstrb}, 32'h0);
        @(posedge clk); #1;
        rst = 1'b0;

        // mem_ack while idle must not start or complete anything.
        mem_ack = 1'b1;
        @(negedge clk);
        check("idle_ack.mem_req", {31'h0, mem_req}, 32'h0);
        check("idle_ack.cpu_stall", {31'h0, cpu_stall}, 32'h0);
        @(posedge clk); #1;
        mem_ack = 1'b0;

        for (int i = 0; i < 15; i++) begin
            run_access($sformatf("v%0d", i), vecs[i]);
        end

        // Flush together with a request: one flush stall, then the cached line refills.
        flush = 1'b1; cpu_req = 1'b1; cpu_we = 1'b0; cpu_byte = 1'b0; cpu_addr = 32'h0003_0004;
        @(negedge clk);
        check("flush.cpu_stall", {31'h0, cpu_stall}, 32'h1);
        check("flush.mem_req", {31'h0, mem_req}, 32'h0);
        check("flush.cpu_rdata", cpu_rdata, 32'h0);
        @(posedge clk); #1;
        flush = 1'b0;
        run_access("after_flush",
                   mk(0, 0, 32'h0003_0004, 32'h0, 32'hA5A5A5A5, 32'hA5A5A5A5, 3, 1, 4'h0, 32'h0));

        // Reset in the middle of a refill, with a late mem_ack afterwards.
        cpu_req = 1'b1; cpu_we = 1'b0; cpu_byte = 1'b0; cpu_addr = 32'h0004_0000;
        mem_rdata = 32'hBAD0BAD0;
        @(negedge clk);
        check("midrst.miss_stall", {31'h0, cpu_stall}, 32'h1);
        @(posedge clk); #1;
        @(negedge clk);
        check("midrst.refill_req", {31'h0, mem_req}, 32'h1);
        @(posedge clk); #1;
        rst = 1'b1; cpu_req = 1'b0;
        @(negedge clk);
        check("midrst.stall_in_rst", {31'h0, cpu_stall}, 32'h0);
        check("midrst.rdata_in_rst", cpu_rdata, 32'h0);
        @(posedge clk); #1;
        rst = 1'b0; mem_ack = 1'b1;
        @(negedge clk);
        check("midrst.mem_req", {31'h0, mem_req}, 32'h0);
        check("midrst.mem_we", {31'h0, mem_we}, 32'h0);
        check("midrst.mem_addr", mem_addr, 32'h0);
        check("midrst.mem_wdata", mem_wdata, 32'h0);
        check("midrst.mem_wstrb", {28'h0, mem_wstrb}, 32'h0);
        check("midrst.cpu_stall", {31'h0, cpu_stall}, 32'h0);
        check("midrst.cpu_rdata", cpu_rdata, 32'h0);
        @(posedge clk); #1;
        mem_ack = 1'b0;
        @(negedge clk);
        check("midrst.late_ack_ignored", {31'h0, mem_req}, 32'h0);
        @(posedge clk); #1;
        run_access("post_rst_abandoned",
                   mk(0, 0, 32'h0004_0000, 32'h0, 32'h40404040, 32'h40404040, 3, 1, 4'h0, 32'h0));
        run_access("post_rst_cleared",
                   mk(0, 0, 32'h0001_0000, 32'h0, 32'hDEAD5AEF, 32'hDEAD5AEF, 3, 1, 4'h0, 32'h0));

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/dcache_ctrl.md
DCACHE_CTRL -- requirements
Module: dcache_ctrl

Interface
REQ-001 Parameters SHALL be: DATA_WIDTH 32 (word width); TAG_WIDTH 27 (tag bits, addr[31:5]); SET_WIDTH 3 (set index, addr[4:2], 8 sets).
REQ-002 Ports SHALL be: clk in 1 (single clock); rst in 1 (synchronous, active-high reset).
REQ-003 cpu_req in 1 (access valid); cpu_we in 1 (store); cpu_byte in 1 (1 = LBU/SB, 0 = LW/SW); cpu_addr in 32; cpu_wdata in 32.
REQ-004 cpu_rdata out 32 (load result); cpu_stall out 1 (hold pipeline); flush in 1 (invalidate all sets).
REQ-005 mem_req out 1; mem_we out 1; mem_addr out 32 (word-aligned); mem_wdata out 32; mem_wstrb out 4; mem_rdata in 32; mem_ack in 1 (one-cycle completion pulse).

Function
REQ-006 The block SHALL implement a direct-mapped, one-word-per-line, write-through cache with a 3-state FSM: IDLE, REFILL, WRITE.
REQ-007 A lookup SHALL be a hit when valid[set] = 1 and tag[set] = cpu_addr[31:5]; the lookup is combinational in IDLE.
REQ-008 In IDLE, a load hit SHALL drive cpu_rdata the same cycle with cpu_stall = 0; LW returns the word, LBU returns the zero-extended byte selected by addr[1:0] (little-endian, byte 0 = bits 7:0).
REQ-009 In IDLE, a load miss SHALL assert cpu_stall combinationally and move to REFILL next cycle.
REQ-010 In REFILL, the block SHALL hold mem_req = 1, mem_we = 0 and mem_addr = {addr[31:2], 2'b00} until mem_ack.
REQ-011 On mem_ack in REFILL, the block SHALL write the line (data, tag, valid = 1), drive cpu_rdata from mem_rdata with the same byte rules, drive cpu_stall = 0 that cycle, and return to IDLE.
REQ-012 In IDLE, any store SHALL assert cpu_stall and move to WRITE.
REQ-013 In WRITE, the block SHALL hold mem_req = 1, mem_we = 1, mem_wdata = cpu_wdata (SB: byte replicated to all 4 lanes) and mem_wstrb = 4'hF (SW) or the one-hot strobe for addr[1:0] (SB).
REQ-014 A store hit SHALL update the cached word (SB: the addressed byte only).
REQ-015 An SW miss SHALL allocate the line; an SB miss SHALL NOT allocate.
REQ-016 The cache array SHALL be updated on the mem_ack cycle; on that cycle cpu_stall = 0 and the FSM returns to IDLE.
REQ-017 mem_ack SHALL be ignored in IDLE.
REQ-018 At most one memory transaction SHALL be outstanding; mem_addr, mem_wdata and mem_wstrb SHALL be registered and held stable while mem_req = 1.
REQ-019 flush SHALL be honoured only in IDLE: all valid bits clear next edge and cpu_stall = 1 that cycle.
REQ-020 When flush and cpu_req are both asserted in IDLE, flush SHALL win and the request is serviced on a following cycle.
REQ-021 flush outside IDLE SHALL be ignored; the requester holds it.
REQ-022 cpu_rdata SHALL be 0 whenever no load completes that cycle.

Reset
REQ-023 rst SHALL force IDLE and clear all valid bits.
REQ-024 rst SHALL drive mem_req, mem_we, mem_wstrb, mem_addr, mem_wdata, cpu_stall and cpu_rdata to 0.
REQ-025 rst asserted mid-REFILL or mid-WRITE SHALL abandon the transaction: no array update, mem_req low the next cycle, and any late mem_ack is ignored.

Configuration
REQ-026 With DCACHE_STATS_EN defined, the block SHALL provide outputs hit_count and miss_count (32-bit, saturating, cleared by rst, incremented once per completed CPU access; flush does not count).
REQ-027 Without DCACHE_STATS_EN, those ports and counters SHALL be absent.

Structure
REQ-028 Package dcache_pkg SHALL hold the FSM state enum, TAG_WIDTH, SET_WIDTH and the byte-strobe decode function.
REQ-029 Storage (valid/tag/data arrays, one read port, one byte-enabled write port, bulk valid clear) SHALL be the sub-module dcache_array; dcache_ctrl holds the FSM and the memory-side registers.

Verification
REQ-030 LW 0x10000 after reset, with mem_ack 3 cycles later and mem_rdata 0xDEADBEEF: stall for 3 cycles, rdata 0xDEADBEEF on the ack cycle; repeat LW then hits with stall 0.
REQ-031 SB 0x10001 data 0x5A after that line is cached: mem_wstrb 4'b0010; a following LW returns 0xDEAD5AEF with no memory request.
REQ-032 SB 0x20003 on a miss: write strobe 4'b1000 issued; a following LBU 0x20003 misses and causes a refill.
REQ-033 LW 0x10000, then LW 0x10020 (same set, new tag), then LW 0x10000: three refills, eviction verified.
REQ-034 flush together with cpu_req in IDLE, then LW on a previously cached line: one stall cycle for the flush, then a refill.
REQ-035 rst pulsed during REFILL, mem_ack arriving afterwards: no array write, FSM in IDLE, outputs at their reset values.
